// File: rtl/gd_dma_arbiter_if.sv
// Bus-side signal bundle between the DMA arbiter and the 6809 core / requesters.
// Latency: none, wires only.
// Flow control: level req from requesters, one-hot gnt back; nDMABREQ/BA/BS handshake with the core.
interface gd_dma_arbiter_if;
  logic       E;
  logic       BA;
  logic       BS;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       nDMABREQ;
  logic       busy;
  logic       timeout_err;

  modport master (
    input  E, BA, BS, req,
    output gnt, nDMABREQ, busy, timeout_err
  );

  modport slave (
    output E, BA, BS, req,
    input  gnt, nDMABREQ, busy, timeout_err
  );
endinterface

// File: rtl/gd_dma_arbiter.sv
// Two-requester round-robin DMA arbiter sharing the 6809 bus via nDMABREQ and the BA/BS grant state.
// Latency: decisions on filtered E fall, E_FILTER+3 fpga6x cycles after raw E falls; outputs one cycle later.
// Flow control: requesters hold level req; a grant lasts at most MAX_CYCLES E cycles, a request aborts after REQ_TIMEOUT.
module gd_dma_arbiter #(
  parameter int MAX_CYCLES  = 14,
  parameter int REQ_TIMEOUT = 32,
  parameter int E_FILTER    = 3
) (
  input  logic              fpga6x,
  input  logic              nRESET,
  gd_dma_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} state_t;

  logic       eMeta, eSync;
  logic       baMeta, baSync;
  logic       bsMeta, bsSync;
  logic [1:0] reqMeta, reqSync;
  logic       efilt, efiltDly, eFall;
  logic [2:0] fCnt;

  state_t     state, stateNxt;
  logic       sel, selNxt;
  logic [7:0] cnt, cntNxt;
  logic       lastOwner, lastOwnerNxt;
  logic       timeoutNxt;
  logic [1:0] gntQ;
  logic       nDmaBreqQ;
  logic       busyQ;
  logic       timeoutErrQ;

  // Two-flop synchronisers for every input that comes from the core's clock domain or the requesters
  always_ff @(posedge fpga6x) begin
    if (!nRESET) begin
      eMeta   <= 1'b0;
      eSync   <= 1'b0;
      baMeta  <= 1'b0;
      baSync  <= 1'b0;
      bsMeta  <= 1'b0;
      bsSync  <= 1'b0;
      reqMeta <= 2'b00;
      reqSync <= 2'b00;
    end else begin
      eMeta   <= bus.E;
      eSync   <= eMeta;
      baMeta  <= bus.BA;
      baSync  <= baMeta;
      bsMeta  <= bus.BS;
      bsSync  <= bsMeta;
      reqMeta <= bus.req;
      reqSync <= reqMeta;
    end
  end

  // E deglitch: accept a new level only after E_FILTER consecutive differing samples
  always_ff @(posedge fpga6x) begin
    if (!nRESET) begin
      efilt <= 1'b0;
      fCnt  <= 3'd0;
    end else if (eSync != efilt) begin
      if (fCnt == 3'(E_FILTER - 1)) begin
        efilt <= eSync;
        fCnt  <= 3'd0;
      end else begin
        fCnt <= fCnt + 3'd1;
      end
    end else begin
      fCnt <= 3'd0;
    end
  end

  // Single-cycle strobe registered one cycle after the filtered E falls
  always_ff @(posedge fpga6x) begin
    if (!nRESET) begin
      efiltDly <= 1'b0;
      eFall    <= 1'b0;
    end else begin
      efiltDly <= efilt;
      eFall    <= efiltDly & ~efilt;
    end
  end

  // Arbiter state and registered outputs, all derived from the next-state decode
  always_ff @(posedge fpga6x) begin
    if (!nRESET) begin
      state       <= IDLE;
      sel         <= 1'b0;
      cnt         <= 8'd0;
      lastOwner   <= 1'b1;
      gntQ        <= 2'b00;
      nDmaBreqQ   <= 1'b1;
      busyQ       <= 1'b0;
      timeoutErrQ <= 1'b0;
    end else begin
      state       <= stateNxt;
      sel         <= selNxt;
      cnt         <= cntNxt;
      lastOwner   <= lastOwnerNxt;
      gntQ        <= (stateNxt == GRANT) ? (selNxt ? 2'b10 : 2'b01) : 2'b00;
      nDmaBreqQ   <= !((stateNxt == REQ) || (stateNxt == GRANT));
      busyQ       <= (stateNxt != IDLE);
      timeoutErrQ <= timeoutNxt;
    end
  end

  // Next-state logic; nothing moves except on a filtered E fall
  always_comb begin
    stateNxt     = state;
    selNxt       = sel;
    cntNxt       = cnt;
    lastOwnerNxt = lastOwner;
    timeoutNxt   = 1'b0;
    if (eFall) begin
      case (state)
        IDLE: begin
          if (|reqSync) begin
            // The requester that did not own the bus last wins when it is asking
            selNxt   = reqSync[~lastOwner] ? ~lastOwner : lastOwner;
            cntNxt   = 8'd0;
            stateNxt = REQ;
          end
        end
        REQ: begin
          if (!reqSync[sel]) begin
            stateNxt = RELEASE;
          end else if (baSync && bsSync) begin
            cntNxt   = 8'd0;
            stateNxt = GRANT;
          end else if (cnt == 8'(REQ_TIMEOUT - 1)) begin
            timeoutNxt = 1'b1;
            stateNxt   = RELEASE;
          end else begin
            cntNxt = cnt + 8'd1;
          end
        end
        GRANT: begin
          // Owner quit, quota used up, or the core took the bus back
          if (!baSync || !reqSync[sel] || (cnt == 8'(MAX_CYCLES - 1))) begin
            lastOwnerNxt = sel;
            stateNxt     = RELEASE;
          end else begin
            cntNxt = cnt + 8'd1;
          end
        end
        RELEASE: begin
          if (!baSync) begin
            stateNxt = IDLE;
          end
        end
        default: stateNxt = IDLE;
      endcase
    end
  end

  assign bus.gnt         = gntQ;
  assign bus.nDMABREQ    = nDmaBreqQ;
  assign bus.busy        = busyQ;
  assign bus.timeout_err = timeoutErrQ;

endmodule

// File: tb/tb_gd_dma_arbiter.sv
// Directed bench for gd_dma_arbiter: E filter, grant length, round-robin, abort, timeout, reset.
// Latency: each eCycle call is one full E period of 16+ fpga6x cycles; outputs sampled on falling fpga6x edges.
// Flow control: requester and core levels driven by the bench; optional core model mirrors nDMABREQ onto BA/BS.
module tb_gd_dma_arbiter;
  logic fpga6x = 1'b0;
  logic nRESET;

  gd_dma_arbiter_if busIf();

  gd_dma_arbiter #(
    .MAX_CYCLES (14),
    .REQ_TIMEOUT(32),
    .E_FILTER   (3)
  ) dut (
    .fpga6x(fpga6x),
    .nRESET(nRESET),
    .bus   (busIf)
  );

  always #5 fpga6x = ~fpga6x;

  int checks   = 0;
  int errors   = 0;
  bit coreAuto = 1'b0;
  int toCount  = 0;

  // Count timeout pulses, sampled away from the active edge
  always @(negedge fpga6x) begin
    if (busIf.timeout_err === 1'b1) toCount <= toCount + 1;
  end

  // One E period: high 8 cycles then low; the decision from this fall is visible on return
  task automatic eCycle();
    @(negedge fpga6x);
    if (coreAuto) begin
      busIf.BA = ~busIf.nDMABREQ;
      busIf.BS = ~busIf.nDMABREQ;
    end
    busIf.E = 1'b1;
    repeat (8) @(negedge fpga6x);
    busIf.E = 1'b0;
    repeat (8) @(negedge fpga6x);
  endtask

  task automatic test_reset();
    nRESET = 1'b0;
    busIf.E = 1'b0; busIf.BA = 1'b0; busIf.BS = 1'b0; busIf.req = 2'b00;
    repeat (3) @(negedge fpga6x);
    checks++; if (busIf.gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", busIf.gnt); end
    checks++; if (busIf.nDMABREQ !== 1'b1) begin errors++; $display("FAIL reset_ndmabreq: got %b expected 1", busIf.nDMABREQ); end
    checks++; if (busIf.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busIf.busy); end
    checks++; if (busIf.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", busIf.timeout_err); end
    nRESET = 1'b1;
    @(negedge fpga6x);
  endtask

  task automatic test_e_filter();
    int seen;
    int lat;
    busIf.E = 1'b1;
    repeat (12) @(negedge fpga6x);
    busIf.req = 2'b01;
    // two-sample low glitch
    busIf.E = 1'b0;
    @(negedge fpga6x);
    @(negedge fpga6x);
    busIf.E = 1'b1;
    seen = 0;
    repeat (14) begin
      @(negedge fpga6x);
      if (dut.eFall === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL glitch_efall: got %0d pulses expected 0", seen); end
    checks++; if (busIf.nDMABREQ !== 1'b1) begin errors++; $display("FAIL glitch_ndmabreq: got %b expected 1", busIf.nDMABREQ); end
    checks++; if (busIf.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b expected 0", busIf.busy); end
    // clean fall
    busIf.E = 1'b0;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge fpga6x);
      if (dut.eFall === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++; if (lat != 6) begin errors++; $display("FAIL efall_latency: got %0d cycles expected 6", lat); end
    @(negedge fpga6x);
    checks++; if (dut.eFall !== 1'b0) begin errors++; $display("FAIL efall_width: got %b expected 0", dut.eFall); end
    checks++; if (busIf.nDMABREQ !== 1'b0) begin errors++; $display("FAIL efall_req_ndmabreq: got %b expected 0", busIf.nDMABREQ); end
    checks++; if (busIf.busy !== 1'b1) begin errors++; $display("FAIL efall_req_busy: got %b expected 1", busIf.busy); end
    // requester withdraws before the core answers: abort through RELEASE
    busIf.req = 2'b00;
    eCycle();
    checks++; if (busIf.nDMABREQ !== 1'b1 || busIf.gnt !== 2'b00 || busIf.busy !== 1'b1) begin
      errors++; $display("FAIL abort_release: got ndmabreq=%b gnt=%b busy=%b expected 1/00/1", busIf.nDMABREQ, busIf.gnt, busIf.busy);
    end
    eCycle();
    checks++; if (busIf.busy !== 1'b0) begin errors++; $display("FAIL abort_idle_busy: got %b expected 0", busIf.busy); end
  endtask

  task automatic test_round_robin();
    logic [1:0] g, prevG, cur;
    logic [1:0] owner [3];
    int         len   [3];
    int         runLen, nRuns;
    prevG = 2'b00; cur = 2'b00; runLen = 0; nRuns = 0;
    for (int i = 0; i < 3; i++) begin owner[i] = 2'b00; len[i] = 0; end
    coreAuto = 1'b1;
    busIf.req = 2'b11;
    for (int c = 0; c < 70 && nRuns < 3; c++) begin
      eCycle();
      g = busIf.gnt;
      checks++; if (g === 2'b11 || (busIf.nDMABREQ === 1'b1 && g !== 2'b00)) begin
        errors++; $display("FAIL rr_exclusive: got gnt=%b ndmabreq=%b expected one-hot and 00 while released", g, busIf.nDMABREQ);
      end
      if (g != 2'b00 && prevG == 2'b00) begin
        cur = g; runLen = 1;
      end else if (g != 2'b00) begin
        if (g != prevG) begin errors++; $display("FAIL rr_gap: got %b after %b expected 00 between", g, prevG); end
        runLen++;
      end else if (prevG != 2'b00) begin
        owner[nRuns] = cur; len[nRuns] = runLen; nRuns++;
      end
      prevG = g;
    end
    checks++; if (nRuns != 3) begin errors++; $display("FAIL rr_runs: got %0d grants expected 3", nRuns); end
    checks++; if (owner[0] !== 2'b01 || owner[1] !== 2'b10 || owner[2] !== 2'b01) begin
      errors++; $display("FAIL rr_order: got %b,%b,%b expected 01,10,01", owner[0], owner[1], owner[2]);
    end
    checks++; if (len[0] != 14 || len[1] != 14 || len[2] != 14) begin
      errors++; $display("FAIL rr_length: got %0d,%0d,%0d expected 14 each", len[0], len[1], len[2]);
    end
    busIf.req = 2'b00;
    eCycle();
    checks++; if (busIf.busy !== 1'b0) begin errors++; $display("FAIL rr_idle_busy: got %b expected 0", busIf.busy); end
    coreAuto = 1'b0;
    busIf.BA = 1'b0; busIf.BS = 1'b0;
  endtask

  task automatic test_single_grant();
    int len;
    busIf.BA = 1'b0; busIf.BS = 1'b0;
    busIf.req = 2'b01;
    eCycle();
    checks++; if (busIf.nDMABREQ !== 1'b0 || busIf.gnt !== 2'b00 || busIf.busy !== 1'b1) begin
      errors++; $display("FAIL single_req: got ndmabreq=%b gnt=%b busy=%b expected 0/00/1", busIf.nDMABREQ, busIf.gnt, busIf.busy);
    end
    eCycle();
    eCycle();
    checks++; if (busIf.gnt !== 2'b00) begin errors++; $display("FAIL single_wait_gnt: got %b expected 00", busIf.gnt); end
    busIf.BA = 1'b1; busIf.BS = 1'b1;
    eCycle();
    checks++; if (busIf.gnt !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b expected 01", busIf.gnt); end
    len = 1;
    for (int k = 0; k < 20; k++) begin
      eCycle();
      if (busIf.gnt === 2'b01) len++;
      else break;
    end
    checks++; if (len != 14) begin errors++; $display("FAIL single_length: got %0d E cycles expected 14", len); end
    checks++; if (busIf.nDMABREQ !== 1'b1 || busIf.gnt !== 2'b00 || busIf.busy !== 1'b1) begin
      errors++; $display("FAIL single_release: got ndmabreq=%b gnt=%b busy=%b expected 1/00/1", busIf.nDMABREQ, busIf.gnt, busIf.busy);
    end
    busIf.BA = 1'b0; busIf.BS = 1'b0; busIf.req = 2'b00;
    eCycle();
    checks++; if (busIf.busy !== 1'b0 || busIf.nDMABREQ !== 1'b1) begin
      errors++; $display("FAIL single_idle: got busy=%b ndmabreq=%b expected 0/1", busIf.busy, busIf.nDMABREQ);
    end
  endtask

  task automatic test_early_drop();
    coreAuto = 1'b1;
    busIf.req = 2'b10;
    eCycle();
    eCycle();
    checks++; if (busIf.gnt !== 2'b10) begin errors++; $display("FAIL drop_gnt: got %b expected 10", busIf.gnt); end
    repeat (3) eCycle();
    checks++; if (busIf.gnt !== 2'b10) begin errors++; $display("FAIL drop_hold: got %b expected 10", busIf.gnt); end
    busIf.req = 2'b00;
    eCycle();
    checks++; if (busIf.gnt !== 2'b00 || busIf.nDMABREQ !== 1'b1) begin
      errors++; $display("FAIL drop_release: got gnt=%b ndmabreq=%b expected 00/1", busIf.gnt, busIf.nDMABREQ);
    end
    eCycle();
    checks++; if (busIf.busy !== 1'b0) begin errors++; $display("FAIL drop_idle: got busy=%b expected 0", busIf.busy); end
    busIf.req = 2'b11;
    eCycle();
    eCycle();
    checks++; if (busIf.gnt !== 2'b01) begin errors++; $display("FAIL drop_rotate: got %b expected 01", busIf.gnt); end
  endtask

  task automatic test_reset_mid_grant();
    checks++; if (busIf.gnt !== 2'b01) begin errors++; $display("FAIL rst_pre_gnt: got %b expected 01", busIf.gnt); end
    nRESET = 1'b0;
    @(negedge fpga6x);
    checks++; if (busIf.gnt !== 2'b00 || busIf.nDMABREQ !== 1'b1 || busIf.busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_grant: got gnt=%b ndmabreq=%b busy=%b expected 00/1/0", busIf.gnt, busIf.nDMABREQ, busIf.busy);
    end
    nRESET = 1'b1;
    coreAuto = 1'b0;
    busIf.BA = 1'b0; busIf.BS = 1'b0; busIf.req = 2'b00;
    eCycle();
    checks++; if (busIf.busy !== 1'b0) begin errors++; $display("FAIL rst_after_busy: got %b expected 0", busIf.busy); end
  endtask

  task automatic test_timeout();
    int hitAt, base;
    bit sawGnt;
    hitAt = 0; sawGnt = 1'b0; base = toCount;
    busIf.BA = 1'b0; busIf.BS = 1'b0;
    busIf.req = 2'b01;
    for (int k = 1; k <= 40; k++) begin
      eCycle();
      if (busIf.gnt !== 2'b00) sawGnt = 1'b1;
      if (toCount != base) begin
        hitAt = k;
        break;
      end
    end
    checks++; if (hitAt != 33) begin errors++; $display("FAIL timeout_at: got E cycle %0d expected 33", hitAt); end
    checks++; if (sawGnt) begin errors++; $display("FAIL timeout_gnt: got a grant expected none"); end
    checks++; if (busIf.nDMABREQ !== 1'b1 || busIf.busy !== 1'b1) begin
      errors++; $display("FAIL timeout_release: got ndmabreq=%b busy=%b expected 1/1", busIf.nDMABREQ, busIf.busy);
    end
    busIf.req = 2'b00;
    eCycle();
    checks++; if (busIf.busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: got busy=%b expected 0", busIf.busy); end
    checks++; if (toCount - base != 1) begin errors++; $display("FAIL timeout_pulses: got %0d expected 1", toCount - base); end
    coreAuto = 1'b1;
    busIf.req = 2'b11;
    eCycle();
    eCycle();
    checks++; if (busIf.gnt !== 2'b01) begin errors++; $display("FAIL timeout_no_rotate: got %b expected 01", busIf.gnt); end
    busIf.req = 2'b00;
    eCycle();
    eCycle();
    checks++; if (busIf.busy !== 1'b0 || busIf.gnt !== 2'b00) begin
      errors++; $display("FAIL final_idle: got busy=%b gnt=%b expected 0/00", busIf.busy, busIf.gnt);
    end
  endtask

  initial begin
    test_reset();
    test_e_filter();
    test_round_robin();
    test_single_grant();
    test_early_drop();
    test_reset_mid_grant();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/gd_dma_arbiter.md
Name: gd_dma_arbiter

Overview:
- Shares the 6809 bus between two external DMA requesters.
- Drives the core's nDMABREQ and waits for the bus-grant state (BA=1, BS=1).
- Issues a one-hot grant to one requester for a bounded number of E cycles, then hands the bus back.
- Sits beside the mc6809 core in the GODIL wrapper, clocked by the fast fpga6x clock; all decisions are taken on a filtered falling edge of E.

Parameters:
- MAX_CYCLES, 14: maximum E cycles per grant before forced release (range 1..15).
- REQ_TIMEOUT, 32: E cycles to wait for BA&BS before aborting a request (range 2..255).
- E_FILTER, 3: consecutive fpga6x samples required to accept a change on E (range 1..7).

Ports:
- fpga6x, input, 1: fast clock; all logic on its rising edge.
- nRESET, input, 1: synchronous, active-low reset.
- E, input, 1: raw E from the core; asynchronous to fpga6x.
- BA, input, 1: core bus-available output; asynchronous.
- BS, input, 1: core bus-status output; asynchronous.
- req, input, 2: DMA requests, level, one bit per requester; asynchronous.
- gnt, output, 2: one-hot grant; owner may drive A/D/RnW while its bit is high.
- nDMABREQ, output, 1: active-low DMA/bus request to the core.
- busy, output, 1: high in any state other than IDLE.
- timeout_err, output, 1: one-fpga6x-cycle pulse when a request is aborted by REQ_TIMEOUT.

Behaviour:
- Input conditioning:
  - E, BA, BS and req each pass through a 2-flop synchroniser.
  - efilt takes the synchronised E value only after E_FILTER consecutive cycles that differ from the current efilt; the counter clears on any matching sample.
  - e_fall is registered high for exactly one fpga6x cycle when efilt goes 1->0.
  - Latency from raw E fall to e_fall high: E_FILTER+3 fpga6x cycles (2 sync + E_FILTER filter + 1 register).
  - Glitches shorter than E_FILTER samples never produce e_fall.
- Sampling: all state transitions and counter updates happen only on cycles with e_fall=1, using the synchronised BA/BS/req values on that cycle.
- States: IDLE, REQ, GRANT, RELEASE.
- IDLE:
  - Outputs: nDMABREQ=1, gnt=00, busy=0.
  - At e_fall with any req bit set: sel = the requester that is not last_owner if it is requesting, else the sole requester.
  - Then clear cnt, set nDMABREQ=0, go to REQ.
  - Both requesting: the one that is not last_owner wins (strict round-robin).
- REQ:
  - nDMABREQ=0, busy=1. At e_fall, checks in priority order:
  - (a) req[sel]=0: go to RELEASE (abort, no grant).
  - (b) BA=1 and BS=1: gnt[sel]=1, cnt=0, go to GRANT.
  - (c) cnt=REQ_TIMEOUT-1: pulse timeout_err, go to RELEASE.
  - (d) otherwise cnt++.
- GRANT:
  - gnt[sel]=1, nDMABREQ=0.
  - At e_fall: if req[sel]=0 or cnt=MAX_CYCLES-1, then gnt=00, nDMABREQ=1, last_owner=sel, go to RELEASE; else cnt++.
  - If BA drops to 0 during GRANT (core reclaimed the bus), at that e_fall: gnt=00 immediately, last_owner=sel, go to RELEASE.
- RELEASE:
  - nDMABREQ=1, gnt=00.
  - Stays at least one full e_fall.
  - At e_fall with BA=0: go to IDLE.
  - Requests arriving here are not served until IDLE.
- Owner rotation:
  - last_owner is updated only when a grant ends.
  - Aborted and timed-out requests do not rotate ownership.
- Grant exclusivity: gnt is never 11. gnt is 00 in every cycle where nDMABREQ=1.
- Reset:
  - On the first fpga6x edge with nRESET=0, from any state: state=IDLE, nDMABREQ=1, gnt=00, busy=0, timeout_err=0, cnt=0, last_owner=1 (requester 0 wins first), efilt=0, filter counter=0, synchronisers=0.
  - Reset mid-GRANT drops gnt in that same cycle.
- Counter widths:
  - cnt is 8 bits.
  - Comparisons are exact equality; cnt never wraps because each state exits at its limit.

Test Plan:
- Single grant: req=01, BA/BS rise to 11 two E cycles after nDMABREQ falls, req held -> gnt=01 for exactly 14 E cycles, then nDMABREQ=1; IDLE after BA=0; busy low afterwards.
- Round-robin: req=11 held continuously -> grants alternate 01, 10, 01, each 14 E cycles, with gnt=00 between grants and never 11.
- Early drop: req=10 is granted, then req dropped after 3 E cycles -> gnt=00 and nDMABREQ=1 at that e_fall; last_owner=1, so a subsequent req=11 grants 01.
- Timeout: req=01 with BA held 0 -> timeout_err pulses once after 32 E cycles, no grant, IDLE reached; next req=11 still grants 01 first.
- E glitch: 2-sample low glitch on E with E_FILTER=3 -> no e_fall, no state change; clean falls give e_fall exactly 6 fpga6x cycles after E falls.
- Reset mid-GRANT: nRESET=0 for one fpga6x cycle while gnt=01 -> next edge gives gnt=00, nDMABREQ=1, busy=0; after release req=11 grants 01.
